// File: rtl/npu_requant_pkg.sv
// Shared types and constants for the NPU requantisation unit.
package npu_requant_pkg;

   localparam int SHIFT_MAX = 47;
   localparam int OUT_MAX   = 127;
   localparam int OUT_MIN   = -128;
   localparam int PROD_W    = 49;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_e;

   typedef struct packed {
      logic [15:0]        scale;
      logic [5:0]         shift;
      logic signed [7:0]  zp;
      logic               relu;
      logic [15:0]        beats;
   } cfg_t;

endpackage

// File: rtl/npu_requant_lane.sv
// One accumulator lane: multiply, round/shift, ReLU + zero point + saturate.
module npu_requant_lane
   import npu_requant_pkg::*;
#(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    en_i,
   input  logic [ACC_W-1:0]        acc_i,
   input  logic [15:0]             scale_i,
   input  logic [5:0]              shift_i,
   input  logic signed [7:0]       zp_i,
   input  logic                    relu_i,
   output logic [OUT_W-1:0]        out_o,
   output logic                    sat_o
);

   localparam int W = PROD_W;
   localparam logic signed [W:0] VMax = (W+1)'(OUT_MAX);
   localparam logic signed [W:0] VMin = (W+1)'(OUT_MIN);

   logic signed [W-1:0] acc_ext, scl_ext, prod_d, prod_q, r_d, r_q;
   logic signed [W:0]   rnd, rnd_sum, rnd_shr, relu_r, zp_ext, v;
   logic [OUT_W-1:0]    out_d, out_q;
   logic                sat_d, sat_q;

   always_comb begin
      acc_ext = {{(W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
      scl_ext = {{(W-16){1'b0}}, scale_i};
      prod_d  = acc_ext * scl_ext;
   end

   // Round half up: add 2^(shift-1) before the arithmetic shift.
   always_comb begin
      rnd     = '0;
      rnd_sum = '0;
      rnd_shr = '0;
      r_d     = prod_q;
      if (shift_i != 6'd0) begin
         rnd     = {{W{1'b0}}, 1'b1} << (shift_i - 6'd1);
         rnd_sum = {prod_q[W-1], prod_q} + rnd;
         rnd_shr = rnd_sum >>> shift_i;
         r_d     = rnd_shr[W-1:0];
      end
   end

   always_comb begin
      relu_r = (relu_i && r_q[W-1]) ? '0 : {r_q[W-1], r_q};
      zp_ext = {{(W+1-8){zp_i[7]}}, zp_i};
      v      = relu_r + zp_ext;
      out_d  = v[OUT_W-1:0];
      sat_d  = 1'b0;
      if (v > VMax) begin
         out_d = OUT_W'(OUT_MAX);
         sat_d = 1'b1;
      end else if (v < VMin) begin
         out_d = OUT_W'(OUT_MIN);
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prod_q <= '0;
         r_q    <= '0;
         out_q  <= '0;
         sat_q  <= 1'b0;
      end else if (en_i) begin
         prod_q <= prod_d;
         r_q    <= r_d;
         out_q  <= out_d;
         sat_q  <= sat_d;
      end
   end

   assign out_o = out_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/npu_requant_unit.sv
// Tile-configured requantisation of INT32 accumulators to INT8, 3-stage pipeline.
module npu_requant_unit
   import npu_requant_pkg::*;
#(
   parameter int unsigned LANES = 16,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cfg_valid_i,
   output logic                      cfg_ready_o,
   input  logic [15:0]               cfg_scale_i,
   input  logic [5:0]                cfg_shift_i,
   input  logic [7:0]                cfg_zp_i,
   input  logic                      cfg_relu_i,
   input  logic [15:0]               cfg_beats_i,
   input  logic                      acc_valid_i,
   output logic                      acc_ready_o,
   input  logic [LANES*ACC_W-1:0]    acc_data_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [LANES*OUT_W-1:0]    out_data_o,
   output logic                      out_last_o,
   output logic                      done_o,
   output logic [15:0]               sat_cnt_o,
   output logic                      busy_o
);

   state_e      state_q, state_d;
   cfg_t        cfg_q, cfg_d;
   logic [15:0] acc_cnt_q, acc_cnt_d;
   logic [15:0] sat_cnt_q, sat_cnt_d;
   logic        s1_valid_q, s2_valid_q, s3_valid_q;
   logic        s1_last_q, s2_last_q, s3_last_q;
   logic        en, in_fire, in_last, out_fire;
   logic [LANES-1:0] lane_sat;
   logic [16:0] n_sat, sat_sum;

   assign en          = !s3_valid_q || out_ready_i;
   assign acc_ready_o = (state_q == StRun) && (acc_cnt_q < cfg_q.beats) && en;
   assign in_fire     = acc_valid_i && acc_ready_o;
   assign in_last     = in_fire && ((acc_cnt_q + 16'd1) == cfg_q.beats);
   assign out_fire    = s3_valid_q && out_ready_i;

   always_comb begin
      n_sat = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         n_sat = n_sat + 17'(lane_sat[k]);
      end
      sat_sum = {1'b0, sat_cnt_q} + n_sat;
   end

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      acc_cnt_d = acc_cnt_q;
      sat_cnt_d = sat_cnt_q;
      if (out_fire) begin
         sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
      unique case (state_q)
         StIdle: begin
            if (cfg_valid_i && (cfg_beats_i != 16'd0)) begin
               cfg_d.scale = cfg_scale_i;
               cfg_d.shift = (cfg_shift_i > 6'(SHIFT_MAX)) ? 6'(SHIFT_MAX) : cfg_shift_i;
               cfg_d.zp    = cfg_zp_i;
               cfg_d.relu  = cfg_relu_i;
               cfg_d.beats = cfg_beats_i;
               acc_cnt_d   = '0;
               sat_cnt_d   = '0;
               state_d     = StRun;
            end
         end
         StRun: begin
            if (in_fire) acc_cnt_d = acc_cnt_q + 16'd1;
            if (in_last) state_d = StDrain;
         end
         StDrain: begin
            if (out_fire && s3_last_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cfg_q      <= '0;
         acc_cnt_q  <= '0;
         sat_cnt_q  <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_last_q  <= 1'b0;
         s3_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         acc_cnt_q <= acc_cnt_d;
         sat_cnt_q <= sat_cnt_d;
         if (en) begin
            s1_valid_q <= in_fire;
            s1_last_q  <= in_last;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      npu_requant_lane #(
         .ACC_W (ACC_W),
         .OUT_W (OUT_W)
      ) u_lane (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .en_i    (en),
         .acc_i   (acc_data_i[k*ACC_W +: ACC_W]),
         .scale_i (cfg_q.scale),
         .shift_i (cfg_q.shift),
         .zp_i    (cfg_q.zp),
         .relu_i  (cfg_q.relu),
         .out_o   (out_data_o[k*OUT_W +: OUT_W]),
         .sat_o   (lane_sat[k])
      );
   end

   assign cfg_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign out_valid_o = s3_valid_q;
   assign out_last_o  = s3_last_q;
   assign done_o      = out_fire && s3_last_q;
   assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_npu_requant_unit.sv
// Directed self-checking bench for npu_requant_unit with hand-computed vectors.
module tb_npu_requant_unit;

   localparam int LANES = 16;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 cfg_valid_i;
   logic                 cfg_ready_o;
   logic [15:0]          cfg_scale_i;
   logic [5:0]           cfg_shift_i;
   logic [7:0]           cfg_zp_i;
   logic                 cfg_relu_i;
   logic [15:0]          cfg_beats_i;
   logic                 acc_valid_i;
   logic                 acc_ready_o;
   logic [LANES*32-1:0]  acc_data_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [LANES*8-1:0]   out_data_o;
   logic                 out_last_o;
   logic                 done_o;
   logic [15:0]          sat_cnt_o;
   logic                 busy_o;

   int n_cmp = 0;
   int n_err = 0;
   int acc_tab[4][16];
   int exp_tab[4][16];

   always #5 clk_i = ~clk_i;

   npu_requant_unit #(
      .LANES (LANES),
      .ACC_W (32),
      .OUT_W (8)
   ) u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cfg_valid_i (cfg_valid_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_scale_i (cfg_scale_i),
      .cfg_shift_i (cfg_shift_i),
      .cfg_zp_i    (cfg_zp_i),
      .cfg_relu_i  (cfg_relu_i),
      .cfg_beats_i (cfg_beats_i),
      .acc_valid_i (acc_valid_i),
      .acc_ready_o (acc_ready_o),
      .acc_data_i  (acc_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .done_o      (done_o),
      .sat_cnt_o   (sat_cnt_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_tabs(input int def_exp);
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < LANES; k++) begin
            acc_tab[b][k] = 0;
            exp_tab[b][k] = def_exp;
         end
      end
   endtask

   function automatic logic [LANES*32-1:0] pack_acc(input int b);
      logic [LANES*32-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*32 +: 32] = 32'(acc_tab[b][k]);
      return v;
   endfunction

   function automatic logic [127:0] pack_exp(input int b);
      logic [127:0] v;
      for (int k = 0; k < LANES; k++) v[k*8 +: 8] = 8'(exp_tab[b][k]);
      return v;
   endfunction

   task automatic do_cfg(input logic [15:0] scale, input logic [5:0] shift, input logic [7:0] zp,
                         input logic relu, input logic [15:0] beats);
      @(negedge clk_i);
      cfg_scale_i = scale;
      cfg_shift_i = shift;
      cfg_zp_i    = zp;
      cfg_relu_i  = relu;
      cfg_beats_i = beats;
      cfg_valid_i = 1'b1;
      #1 chk("cfg_ready", 128'(cfg_ready_o), 128'd1);
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
   endtask

   task automatic run_tile(input int nb, input int stall_len, input int exp_sat, input string tag);
      int sent = 0;
      int got = 0;
      int dones = 0;
      int stall_left = stall_len;
      int last_cyc = -1;
      bit stalling = 1'b0;
      bit held_ok = 1'b0;
      logic [127:0] held = '0;
      for (int cyc = 0; cyc < 100 && got < nb; cyc++) begin
         @(negedge clk_i);
         if (out_valid_o && stall_len > 0 && !stalling && got == 0) stalling = 1'b1;
         out_ready_i = !(stalling && stall_left > 0);
         acc_valid_i = (sent < nb);
         acc_data_i  = pack_acc(sent < nb ? sent : 0);
         #1;
         if (done_o) dones++;
         if (out_valid_o && !out_ready_i) begin
            chk({tag, "_stall_acc_ready"}, 128'(acc_ready_o), 128'd0);
            if (held_ok) chk({tag, "_hold"}, {out_data_o}, held);
            held    = out_data_o;
            held_ok = 1'b1;
            stall_left--;
         end
         if (out_valid_o && out_ready_i) begin
            chk({tag, "_data"}, out_data_o, pack_exp(got));
            chk({tag, "_last"}, 128'(out_last_o), 128'(got == nb - 1));
            got++;
            if (got == nb) last_cyc = cyc;
         end
         if (acc_valid_i && acc_ready_o) sent++;
      end
      acc_valid_i = 1'b0;
      out_ready_i = 1'b1;
      chk({tag, "_beats_out"}, 128'(got), 128'(nb));
      chk({tag, "_latency"}, 128'(last_cyc), 128'(nb + 2 + stall_len));
      chk({tag, "_done_pulses"}, 128'(dones), 128'd1);
      @(negedge clk_i);
      #1;
      chk({tag, "_busy_end"}, 128'(busy_o), 128'd0);
      chk({tag, "_sat_cnt"}, 128'(sat_cnt_o), 128'(exp_sat));
   endtask

   initial begin
      bit seen;
      rst_ni      = 1'b0;
      cfg_valid_i = 1'b0;
      cfg_scale_i = '0;
      cfg_shift_i = '0;
      cfg_zp_i    = '0;
      cfg_relu_i  = 1'b0;
      cfg_beats_i = '0;
      acc_valid_i = 1'b0;
      acc_data_i  = '0;
      out_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("rst_cfg_ready", 128'(cfg_ready_o), 128'd1);
      chk("rst_busy", 128'(busy_o), 128'd0);
      chk("rst_out_valid", 128'(out_valid_o), 128'd0);
      chk("rst_acc_ready", 128'(acc_ready_o), 128'd0);
      chk("rst_sat_cnt", 128'(sat_cnt_o), 128'd0);
      chk("rst_out_data", out_data_o, 128'd0);
      chk("rst_last_done", 128'({out_last_o, done_o}), 128'd0);

      // Pass-through with saturation on both rails
      clr_tabs(0);
      acc_tab[0][0] = 100;  exp_tab[0][0] = 100;
      acc_tab[0][1] = 200;  exp_tab[0][1] = 127;
      acc_tab[0][2] = -300; exp_tab[0][2] = -128;
      do_cfg(16'd1, 6'd0, 8'd0, 1'b0, 16'd1);
      run_tile(1, 0, 2, "sat");

      // Scale and round-half-up shift
      clr_tabs(0);
      acc_tab[0][0] = 5;  exp_tab[0][0] = 4;
      acc_tab[0][1] = -5; exp_tab[0][1] = -4;
      acc_tab[0][2] = 6;  exp_tab[0][2] = 5;
      do_cfg(16'd3, 6'd2, 8'd0, 1'b0, 16'd1);
      run_tile(1, 0, 0, "round");

      // ReLU then zero point
      clr_tabs(10);
      acc_tab[0][0] = -50; exp_tab[0][0] = 10;
      acc_tab[0][1] = 20;  exp_tab[0][1] = 30;
      do_cfg(16'd1, 6'd0, 8'd10, 1'b1, 16'd1);
      run_tile(1, 0, 0, "relu");

      // Shift above the limit behaves as 47
      clr_tabs(0);
      acc_tab[0][0] = 32'sh7FFFFFFF; exp_tab[0][0] = 1;
      acc_tab[0][1] = 32'sh80000000; exp_tab[0][1] = -1;
      do_cfg(16'hFFFF, 6'd63, 8'd0, 1'b0, 16'd1);
      run_tile(1, 0, 0, "shmax");

      // 4-beat tile, output stalled 5 cycles at first out_valid
      clr_tabs(-3);
      acc_tab[0][0] = 7;     exp_tab[0][0] = 1;
      acc_tab[0][1] = 3;     exp_tab[0][1] = -1;
      acc_tab[1][0] = -7;    exp_tab[1][0] = -6;
      acc_tab[1][1] = -3;    exp_tab[1][1] = -4;
      acc_tab[2][0] = 300;   exp_tab[2][0] = 127;
      acc_tab[3][0] = -1000; exp_tab[3][0] = -128;
      do_cfg(16'd1, 6'd1, 8'hFD, 1'b0, 16'd4);
      run_tile(4, 5, 2, "stall");

      // Same tile back to back without stalls
      do_cfg(16'd1, 6'd1, 8'hFD, 1'b0, 16'd4);
      run_tile(4, 0, 2, "b2b");

      // Reset in the middle of an 8-beat tile
      clr_tabs(0);
      acc_tab[0][0] = 1000;
      do_cfg(16'd1, 6'd0, 8'd0, 1'b0, 16'd8);
      @(negedge clk_i);
      acc_valid_i = 1'b1;
      acc_data_i  = pack_acc(0);
      #1 chk("mid_acc_ready", 128'(acc_ready_o), 128'd1);
      @(negedge clk_i);
      @(negedge clk_i);
      acc_valid_i = 1'b0;
      rst_ni      = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("mid_out_valid", 128'(out_valid_o), 128'd0);
      chk("mid_sat_cnt", 128'(sat_cnt_o), 128'd0);
      chk("mid_busy", 128'(busy_o), 128'd0);
      chk("mid_cfg_ready", 128'(cfg_ready_o), 128'd1);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         if (out_valid_o) seen = 1'b1;
      end
      chk("mid_no_partial", 128'(seen), 128'd0);

      // Zero-beat config is ignored
      @(negedge clk_i);
      cfg_beats_i = 16'd0;
      cfg_valid_i = 1'b1;
      acc_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         #1;
         chk("zb_busy", 128'(busy_o), 128'd0);
         chk("zb_acc_ready", 128'(acc_ready_o), 128'd0);
      end
      cfg_valid_i = 1'b0;
      acc_valid_i = 1'b0;

      // Unit still takes a tile afterwards
      clr_tabs(0);
      acc_tab[0][0] = 100;  exp_tab[0][0] = 100;
      acc_tab[0][1] = 200;  exp_tab[0][1] = 127;
      acc_tab[0][2] = -300; exp_tab[0][2] = -128;
      do_cfg(16'd1, 6'd0, 8'd0, 1'b0, 16'd1);
      run_tile(1, 0, 2, "again");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
